serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial two's-complement subtractor that computes `diff = a - b` one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart to the team's ripple adder cells: the same gate-level arithmetic, traded for area by iterating over time. It sits in the lab ALU datapath wherever an N-bit subtract is needed without N parallel cells.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is ≥ 1.
- `clk`  in  1: single clock; rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; sampled only in IDLE or DONE.
- `a`  in  WIDTH: minuend; sampled on the accepted `start` edge only.
- `b`  in  WIDTH: subtrahend; sampled on the accepted `start` edge only.
- `busy`  out  1: high while bits are being processed.
- `done`  out  1: one-cycle pulse when the result is valid.
- `diff`  out  WIDTH: result, `a - b` modulo 2^WIDTH.
- `borrow_out`  out  1: final borrow; 1 iff `a < b` unsigned.
- `overflow`  out  1: signed overflow; `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with `start`=1:
  - latch `a` into the A shift register and `b` into the B shift register;
  - clear the borrow flop and the bit counter;
  - go to SHIFT.
- SHIFT, each cycle:
  - the cell takes `A[0]`, `B[0]` and the borrow flop;
  - difference bit = `A[0] ^ B[0] ^ bin`;
  - borrow = `(~A[0] & B[0]) | (~(A[0] ^ B[0]) & bin)`;
  - the difference bit shifts into the result register from the MSB end; A and B shift right by one;
  - the borrow flop updates and the counter increments.
- Counter reaches WIDTH-1 in SHIFT: that final bit is processed, then the FSM goes to DONE.
- DONE:
  - `done`=1 for exactly this cycle;
  - `diff`, `borrow_out` and `overflow` are registered and valid;
  - the FSM returns to IDLE unless `start`=1, in which case new operands are latched and the FSM goes straight to SHIFT (back-to-back).
- Outputs `diff`, `borrow_out` and `overflow` hold their last values until the next DONE. They do not change during SHIFT; the result register is separate from the output register.
- `start` during SHIFT is ignored; no queuing.
- `overflow` is computed from the latched MSBs of `a` and `b` and the final difference bit.
- WIDTH=1: exactly one SHIFT cycle.
- Counter width is `$clog2(WIDTH)`, minimum 1.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE; `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `overflow`=0; all internal registers 0.
- Reset mid-operation aborts immediately. Outputs go to their reset values, and no `done` is issued after release.
- Cycle numbering: `start` is sampled at edge 0.
  - `busy`=1 during cycles 1..WIDTH.
  - `done`=1 in cycle WIDTH+1.
  - Outputs are valid from cycle WIDTH+1 onward.
- Latency from `start` to `done`: WIDTH+1 cycles.
- Throughput: one operation per WIDTH+1 cycles when `start` is asserted in the DONE cycle.
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package `arith_pkg`:
  - FSM state enum `sub_state_t` (IDLE, SHIFT, DONE);
  - constant `SUB_DEFAULT_WIDTH`=8.
- Sub-module `fsc` (full-subtractor cell):
  - inputs `a`, `b`, `borrow_in`;
  - outputs `diff`, `borrow_out`;
  - purely combinational, instantiated once.
- Top-level `serial_sub` holds the FSM, counter, A/B/result shift registers, borrow flop and output registers.

## Test plan (WIDTH=8)
- `a`=0x05, `b`=0x03, pulse `start` -> `busy` for 8 cycles; then `done` with `diff`=0x02, `borrow_out`=0, `overflow`=0.
- `a`=0x03, `b`=0x05 -> `diff`=0xFE, `borrow_out`=1, `overflow`=0.
- `a`=0x80, `b`=0x01 -> `diff`=0x7F, `borrow_out`=0, `overflow`=1.
- `a`=0x7F, `b`=0xFF -> `diff`=0x80, `borrow_out`=1, `overflow`=1.
- Change `a`/`b` and pulse `start` mid-SHIFT -> ignored; result matches the originally latched operands and `done` lands at cycle 9.
- Assert `rst_n`=0 at cycle 4 of an operation -> all outputs 0 immediately; no `done` after release. Then a back-to-back pair (second `start` in the DONE cycle) yields two `done` pulses 9 cycles apart, each with the correct `diff`.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the lab ALU datapath cells.
// Holds the serial subtractor FSM encoding and its default operand width.
package arith_pkg;

    localparam int unsigned SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/fsc.sv
// Full-subtractor cell: one bit of a - b - borrow_in.
// Purely combinational.
module fsc (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic a_xor_b;

    always_comb begin
        a_xor_b    = a ^ b;
        diff       = a_xor_b ^ borrow_in;
        borrow_out = (~a & b) | (~a_xor_b & borrow_in);
    end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single fsc cell is iterated over WIDTH cycles with a registered borrow.
module serial_sub
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bor_q, bor_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;

    logic cell_diff;
    logic cell_borrow;

    fsc u_fsc (
        .a          (a_sr_q[0]),
        .b          (b_sr_q[0]),
        .borrow_in  (bor_q),
        .diff       (cell_diff),
        .borrow_out (cell_borrow)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_d        = res_q;
        bor_d        = bor_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // Result fills from the MSB end so the last bit lands at WIDTH-1.
                res_d          = res_q >> 1;
                res_d[WIDTH-1] = cell_diff;
                a_sr_d         = a_sr_q >> 1;
                b_sr_d         = b_sr_q >> 1;
                bor_d          = cell_borrow;
                cnt_d          = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d      = StDone;
                    diff_d       = res_d;
                    borrow_out_d = cell_borrow;
                    overflow_d   = (a_msb_q != b_msb_q) && (cell_diff != a_msb_q);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_q        <= '0;
            bor_q        <= 1'b0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_q        <= res_d;
            bor_q        <= bor_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        busy       = (state_q == StShift);
        done       = (state_q == StDone);
        diff       = diff_q;
        borrow_out = borrow_out_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub at WIDTH=8 with hand-computed results.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_serial_sub;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int n_checks;
    int n_bad;

    serial_sub #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drives a start pulse sampled at the next rising edge (cycle 0); returns in cycle 1.
    task automatic issue_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called in cycle 1; checks busy through cycle W, then the DONE cycle W+1.
    task automatic finish_op(input string tag, input logic [W-1:0] ed, input logic eb,
                             input logic eo);
        for (int k = 1; k <= int'(W); k++) begin
            check_eq({tag, " busy"}, 32'(busy), 32'd1);
            check_eq({tag, " no done"}, 32'(done), 32'd0);
            if (k < int'(W)) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " busy low"}, 32'(busy), 32'd0);
        check_eq({tag, " diff"}, 32'(diff), 32'(ed));
        check_eq({tag, " borrow"}, 32'(borrow_out), 32'(eb));
        check_eq({tag, " ovf"}, 32'(overflow), 32'(eo));
    endtask

    typedef struct {
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    vec_t vecs[6];
    int   done_cnt;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_bad    = 0;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst diff", 32'(diff), 32'd0);
        check_eq("rst borrow", 32'(borrow_out), 32'd0);
        check_eq("rst ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            issue_start(vecs[i].av, vecs[i].bv);
            finish_op($sformatf("vec%0d", i), vecs[i].ed, vecs[i].eb, vecs[i].eo);
            @(posedge clk);
            #1;
            check_eq($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            check_eq($sformatf("vec%0d hold", i), 32'(diff), 32'(vecs[i].ed));
        end

        // Start and operand changes mid-SHIFT must be ignored.
        issue_start(8'h5A, 8'h21);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 4; k <= int'(W); k++) begin
            check_eq("mid busy", 32'(busy), 32'd1);
            if (k < int'(W)) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        check_eq("mid done", 32'(done), 32'd1);
        check_eq("mid diff", 32'(diff), 32'h39);
        check_eq("mid borrow", 32'(borrow_out), 32'd0);
        check_eq("mid ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);

        // Reset in cycle 4 aborts; outputs clear at once and no done follows.
        issue_start(8'h10, 8'h01);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort busy", 32'(busy), 32'd0);
        check_eq("abort done", 32'(done), 32'd0);
        check_eq("abort diff", 32'(diff), 32'd0);
        check_eq("abort borrow", 32'(borrow_out), 32'd0);
        check_eq("abort ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("abort no done", 32'(done_cnt), 32'd0);
        check_eq("abort diff hold", 32'(diff), 32'd0);

        // Back-to-back: second start in the DONE cycle of the first.
        issue_start(8'h10, 8'h20);
        finish_op("b2b0", 8'hF0, 1'b1, 1'b0);
        start = 1'b1;
        a     = 8'hC8;
        b     = 8'h37;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op("b2b1", 8'h91, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("b2b idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
